// File: rtl/wdt_pkg.sv
// Shared types and default timing for the watchdog reset escalation stage.
package wdt_pkg;

  localparam int unsigned WDT_W                = 4;
  localparam int unsigned GRACE_CYCLES_DEF     = 8;
  localparam int unsigned RST_PULSE_CYCLES_DEF = 4;
  localparam int unsigned HOLDOFF_CYCLES_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARN    = 2'd1,
    RESET   = 2'd2,
    RECOVER = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/wdt_reset_ctrl_sat_counter.sv
// Generic saturating up-counter with async active-low reset.
module wdt_reset_ctrl_sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog escalation: warning irq, then timed system reset pulse, then holdoff.
module wdt_reset_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES     = GRACE_CYCLES_DEF,
  parameter int unsigned RST_PULSE_CYCLES = RST_PULSE_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES   = HOLDOFF_CYCLES_DEF,
  parameter int unsigned CNT_W            = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             timeout,
  input  logic             irq_ack,
  input  logic             cause_clr,
  output logic             wdt_restart,
  output logic             irq,
  output logic             sys_rst_n,
  output logic             rst_cause,
  output logic [CNT_W-1:0] reset_count
);

  localparam int unsigned MAX_A    = (GRACE_CYCLES > RST_PULSE_CYCLES) ? GRACE_CYCLES : RST_PULSE_CYCLES;
  localparam int unsigned MAX_LEN  = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int unsigned MAX_LOAD = MAX_LEN - 1;
  localparam int unsigned CTR_W    = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

  localparam logic [CTR_W-1:0] GRACE_LOAD = CTR_W'(GRACE_CYCLES - 1);
  localparam logic [CTR_W-1:0] PULSE_LOAD = CTR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LOAD  = CTR_W'(HOLDOFF_CYCLES - 1);

  wdt_state_e       state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             irq_d, sys_rst_n_d, wdt_restart_d;
  logic             rst_entry;

  // State, shared down-counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      irq         <= 1'b0;
      sys_rst_n   <= 1'b1;
      wdt_restart <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      irq         <= irq_d;
      sys_rst_n   <= sys_rst_n_d;
      wdt_restart <= wdt_restart_d;
    end
  end

  // Next state, counter reload/decrement and next output values.
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    irq_d         = 1'b0;
    sys_rst_n_d   = 1'b1;
    wdt_restart_d = 1'b0;
    rst_entry     = 1'b0;
    case (state_q)
      IDLE: begin
        // timeout is stale while a restart is still propagating to the watchdog
        if (enable && timeout && !wdt_restart) begin
          state_d = WARN;
          ctr_d   = GRACE_LOAD;
          irq_d   = 1'b1;
        end
      end
      WARN: begin
        if (irq_ack) begin
          state_d       = IDLE;
          wdt_restart_d = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (ctr_q == '0) begin
          state_d       = RESET;
          ctr_d         = PULSE_LOAD;
          sys_rst_n_d   = 1'b0;
          wdt_restart_d = 1'b1;
          rst_entry     = 1'b1;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
          irq_d = 1'b1;
        end
      end
      RESET: begin
        wdt_restart_d = 1'b1;
        if (ctr_q == '0) begin
          state_d = RECOVER;
          ctr_d   = HOLD_LOAD;
        end else begin
          ctr_d       = ctr_q - CTR_W'(1);
          sys_rst_n_d = 1'b0;
        end
      end
      RECOVER: begin
        if (ctr_q == '0) begin
          state_d = IDLE;
        end else begin
          ctr_d         = ctr_q - CTR_W'(1);
          wdt_restart_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky cause flag; a reset entry beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cause <= 1'b0;
    end else if (rst_entry) begin
      rst_cause <= 1'b1;
    end else if (cause_clr) begin
      rst_cause <= 1'b0;
    end
  end

  wdt_reset_ctrl_sat_counter #(
    .W(CNT_W)
  ) u_reset_count (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rst_entry),
    .count(reset_count)
  );

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Self-checking bench for wdt_reset_ctrl: directed scenarios plus randomized traffic.
module tb_wdt_reset_ctrl;

  localparam int G = 8;
  localparam int R = 4;
  localparam int H = 2;

  localparam int P_IDLE = 0;
  localparam int P_WARN = 1;
  localparam int P_PULSE = 2;
  localparam int P_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n, enable, timeout, irq_ack, cause_clr;
  logic       wdt_restart, irq, sys_rst_n, rst_cause;
  logic [3:0] reset_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model: phase, cycles left in phase, and the observable flags
  int m_phase, m_left, m_count;
  bit m_restart, m_cause;

  wdt_reset_ctrl #(
    .GRACE_CYCLES(G), .RST_PULSE_CYCLES(R), .HOLDOFF_CYCLES(H), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .timeout(timeout),
    .irq_ack(irq_ack), .cause_clr(cause_clr), .wdt_restart(wdt_restart),
    .irq(irq), .sys_rst_n(sys_rst_n), .rst_cause(rst_cause),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_count = 0; m_restart = 1'b1; m_cause = 1'b0;
  endtask

  // One clock of the escalation rules, applied to the inputs seen at the edge.
  task automatic model_step();
    bit entered = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (enable && timeout && !m_restart) begin m_phase = P_WARN; m_left = G; end
        m_restart = 1'b0;
      end
      P_WARN: begin
        if (irq_ack) begin m_phase = P_IDLE; m_restart = 1'b1; end
        else if (!enable) m_phase = P_IDLE;
        else if (m_left == 1) begin
          m_phase = P_PULSE; m_left = R; m_restart = 1'b1; entered = 1'b1;
        end else m_left--;
      end
      P_PULSE: begin
        if (m_left == 1) begin m_phase = P_HOLD; m_left = H; end
        else m_left--;
      end
      default: begin
        if (m_left == 1) begin m_phase = P_IDLE; m_restart = 1'b0; end
        else m_left--;
      end
    endcase
    if (entered) m_cause = 1'b1;
    else if (cause_clr) m_cause = 1'b0;
    if (entered && m_count < 15) m_count++;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq", 8'(irq), 8'(m_phase == P_WARN));
      check("sys_rst_n", 8'(sys_rst_n), 8'(m_phase != P_PULSE));
      check("wdt_restart", 8'(wdt_restart), 8'(m_restart));
      check("rst_cause", 8'(rst_cause), 8'(m_cause));
      check("reset_count", 8'(reset_count), 8'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic run_count(input int n, inout int ci, inout int cl, inout int cr);
    for (int i = 0; i < n; i++) begin
      tick();
      ci += int'(irq);
      cl += int'(!sys_rst_n);
      cr += int'(wdt_restart);
    end
  endtask

  initial begin
    int ci, cl, cr;
    rst_n = 1'b0; enable = 1'b0; timeout = 1'b0; irq_ack = 1'b0; cause_clr = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // power-on
    repeat (3) @(posedge clk);
    #1;
    check("por_irq", 8'(irq), 8'd0);
    check("por_sys_rst_n", 8'(sys_rst_n), 8'd1);
    check("por_count", 8'(reset_count), 8'd0);
    rst_n = 1'b1;
    check("por_restart_hold", 8'(wdt_restart), 8'd1);
    tick();
    check("por_restart_drop", 8'(wdt_restart), 8'd0);

    // kick on 3rd irq cycle
    enable = 1'b1; timeout = 1'b1;
    ci = 0; cl = 0; cr = 0;
    run_count(3, ci, cl, cr);
    irq_ack = 1'b1;
    run_count(1, ci, cl, cr);
    irq_ack = 1'b0;
    check("kick_restart", 8'(wdt_restart), 8'd1);
    run_count(1, ci, cl, cr);
    timeout = 1'b0;
    run_count(4, ci, cl, cr);
    check("kick_irq_cycles", 8'(ci), 8'd3);
    check("kick_restart_cycles", 8'(cr), 8'd1);
    check("kick_no_reset", 8'(cl), 8'd0);

    // escalation
    timeout = 1'b1;
    ci = 0; cl = 0; cr = 0;
    run_count(9, ci, cl, cr);
    timeout = 1'b0;
    run_count(8, ci, cl, cr);
    check("esc_irq_cycles", 8'(ci), 8'd8);
    check("esc_rst_cycles", 8'(cl), 8'd4);
    check("esc_restart_cycles", 8'(cr), 8'd6);
    check("esc_cause", 8'(rst_cause), 8'd1);
    check("esc_count", 8'(reset_count), 8'd1);

    // ack in the final grace cycle
    timeout = 1'b1;
    ci = 0; cl = 0; cr = 0;
    run_count(8, ci, cl, cr);
    irq_ack = 1'b1;
    run_count(1, ci, cl, cr);
    irq_ack = 1'b0; timeout = 1'b0;
    check("lateack_restart", 8'(wdt_restart), 8'd1);
    run_count(6, ci, cl, cr);
    check("lateack_irq_cycles", 8'(ci), 8'd8);
    check("lateack_no_reset", 8'(cl), 8'd0);
    check("lateack_count", 8'(reset_count), 8'd1);

    // disable during warning
    timeout = 1'b1;
    ci = 0; cl = 0; cr = 0;
    run_count(2, ci, cl, cr);
    enable = 1'b0;
    run_count(1, ci, cl, cr);
    check("dis_irq", 8'(irq), 8'd0);
    check("dis_restart", 8'(wdt_restart), 8'd0);
    timeout = 1'b0;
    run_count(4, ci, cl, cr);
    check("dis_no_reset", 8'(cl), 8'd0);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("clr_cause", 8'(rst_cause), 8'd0);
    check("clr_count_kept", 8'(reset_count), 8'd1);

    // saturation
    enable = 1'b1;
    for (int e = 0; e < 17; e++) begin
      timeout = 1'b1;
      run_count(9, ci, cl, cr);
      timeout = 1'b0;
      run_count(6, ci, cl, cr);
    end
    check("sat_count", 8'(reset_count), 8'd15);

    // async reset during 2nd pulse cycle
    timeout = 1'b1;
    ci = 0; cl = 0; cr = 0;
    run_count(10, ci, cl, cr);
    check("mid_rst_low", 8'(sys_rst_n), 8'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_sys_rst_n", 8'(sys_rst_n), 8'd1);
    check("arst_count", 8'(reset_count), 8'd0);
    check("arst_restart", 8'(wdt_restart), 8'd1);
    enable = 1'b0; timeout = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 8) != 0;
      timeout   = ($urandom % 2) != 0;
      irq_ack   = ($urandom % 10) == 0;
      cause_clr = ($urandom % 16) == 0;
      tick();
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wdt_reset_ctrl.md
Name: wdt_reset_ctrl

Overview:
Escalation stage directly downstream of the 4-bit watchdog counter. It consumes the watchdog `timeout` level and first raises a warning interrupt. If software does not acknowledge within a grace window, it issues a timed system reset pulse. It drives `wdt_restart` back to the watchdog to clear it, and keeps a sticky cause flag plus a saturating count of watchdog-induced resets.

Parameters:
GRACE_CYCLES, 8, cycles irq stays high awaiting ack before escalation (>=1)
RST_PULSE_CYCLES, 4, cycles sys_rst_n held low (>=1)
HOLDOFF_CYCLES, 2, cycles after reset pulse with timeout ignored and wdt_restart held (>=1)
CNT_W, 4, width of reset_count

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset; power-on domain, never driven by sys_rst_n
enable  input  1  watchdog enable; same signal that drives the watchdog enable
timeout  input  1  level from watchdog; high while counter == 4'b1111
irq_ack  input  1  software acknowledge (kick), sampled on clk
cause_clr  input  1  clears rst_cause, sampled on clk
wdt_restart  output  1  registered; drives watchdog restart (synchronous clear)
irq  output  1  registered; warning interrupt
sys_rst_n  output  1  registered; active-low system reset request
rst_cause  output  1  registered; sticky "last reset was watchdog"
reset_count  output  CNT_W  registered; saturating count of issued reset pulses

Behaviour:
- Reset (rst_n=0, async) values: state=IDLE, irq=0, sys_rst_n=1, wdt_restart=1, rst_cause=0, reset_count=0, internal counter=0. wdt_restart drops to 0 on the first clk edge after release.
- All outputs are registered from next-state logic. There is no combinational path from input to output.
- FSM states: IDLE, WARN, RESET, RECOVER.
- IDLE:
  - irq=0, sys_rst_n=1.
  - If enable=1, timeout=1 and wdt_restart=0 (current registered value), go to WARN and load the counter with GRACE_CYCLES-1.
  - timeout is ignored while wdt_restart=1. This covers the one-cycle lag before the watchdog counter clears.
- WARN:
  - irq=1.
  - If irq_ack=1, go to IDLE with wdt_restart=1 for exactly one cycle.
  - Else if enable=0, go to IDLE; irq drops and wdt_restart stays 0.
  - Else if counter==0, go to RESET and load RST_PULSE_CYCLES-1.
  - Else decrement the counter.
  - irq is high for exactly GRACE_CYCLES cycles when no ack is given.
- RESET:
  - sys_rst_n=0, wdt_restart=1, irq=0, for exactly RST_PULSE_CYCLES cycles.
  - On entry edge: rst_cause<=1 and reset_count<=reset_count+1, saturating at all-ones.
  - Not abortable. irq_ack and enable are ignored.
  - When counter==0, go to RECOVER and load HOLDOFF_CYCLES-1.
- RECOVER:
  - sys_rst_n=1, wdt_restart=1, irq=0; timeout and irq_ack are ignored.
  - After HOLDOFF_CYCLES cycles, go to IDLE. wdt_restart falls on that edge.
- Simultaneous events:
  - irq_ack and counter==0 in WARN: ack wins, no reset.
  - irq_ack and enable=0 in WARN: ack wins (restart pulse issued).
  - irq_ack in IDLE, RESET or RECOVER: no effect.
- cause_clr:
  - Clears rst_cause in any state, except on the RESET entry edge, where the set wins.
  - reset_count is cleared only by rst_n.
- Asserting rst_n mid-RESET immediately returns sys_rst_n to 1 and all state to reset values.

Decomposition:
- Shared package wdt_pkg:
  - state encoding typedef (IDLE=2'd0, WARN=2'd1, RESET=2'd2, RECOVER=2'd3);
  - default timing constants GRACE_CYCLES_DEF, RST_PULSE_CYCLES_DEF, HOLDOFF_CYCLES_DEF;
  - watchdog width constant WDT_W=4.
- No sub-module is needed beyond an optional sat_counter (generic saturating up-counter, width CNT_W) for reset_count. The single down-counter shared by WARN, RESET and RECOVER stays inline.

Test Plan:
- Power-on: rst_n=0 for 3 cycles then release -> irq=0, sys_rst_n=1, reset_count=0, wdt_restart=1 until the first edge after release, then 0.
- Kick in time: enable=1, timeout rises, irq_ack pulsed on the 3rd irq cycle -> irq high for 3 cycles, wdt_restart high for 1 cycle, no re-entry to WARN, sys_rst_n stays 1.
- Escalation: timeout held, no ack -> irq high for exactly 8 cycles, then sys_rst_n low for exactly 4 cycles, wdt_restart high for 6 cycles, rst_cause=1, reset_count=1.
- Ack at expiry: irq_ack asserted in the 8th irq cycle -> no reset, one-cycle wdt_restart.
- Disable in WARN: enable dropped in the 2nd irq cycle -> IDLE, irq=0, no reset. Then cause_clr pulse after an escalation -> rst_cause=0, reset_count unchanged.
- Saturation and async reset: 17 escalations -> reset_count=4'hF. Then rst_n asserted during the 2nd RESET cycle -> sys_rst_n=1 immediately, reset_count=0.
